// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a 4-word line from a registered data memory while stalling the pipeline.
module dcache_direct #(
  parameter int SETS = 8,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic             MemWE,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWriteData,
  input  logic [31:0]      MemReadData,
  output logic [CNT_W-1:0] HitCount,
  output logic [CNT_W-1:0] MissCount
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;
  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [27:0] miss_q, miss_d;
  logic [CNT_W-1:0] hit_q, hit_d, mcnt_q, mcnt_d;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0] tag_q [SETS];
  logic [31:0] data_q [SETS][LINE_WORDS];
  logic [IW-1:0] idx, midx;
  logic [TW-1:0] tag;
  logic [1:0] off, wr_off;
  logic refill, done, hit, st, ld, ld_hit, ld_miss;
  always_comb begin
    idx = Address[4 +: IW];
    tag = Address[31 -: TW];
    off = Address[3:2];
    midx = miss_q[IW-1:0];
    wr_off = cnt_q[1:0] - 2'd1;
    refill = state_q == REFILL;
    done = refill && cnt_q == 3'd4;
    hit = valid_q[idx] && tag_q[idx] == tag;
    st = !RST && !refill && MemWrite;
    ld = !RST && !refill && !MemWrite && MemRead;
    ld_hit = ld && hit;
    ld_miss = ld && !hit;
    Stall = refill || ld_miss;
    MemWE = st;
    MemAddress = refill ? {miss_q, cnt_q[1:0], 2'b00} : Address;
    MemWriteData = WriteData;
    ReadData = ld_hit ? data_q[idx][off] : '0;
    state_d = done ? IDLE : ld_miss ? REFILL : state_q;
    cnt_d = (refill && !done) ? cnt_q + 3'd1 : 3'd0;
    miss_d = ld_miss ? Address[31:4] : miss_q;
    hit_d = hit_q + CNT_W'(ld_hit);
    mcnt_d = mcnt_q + CNT_W'(ld_miss);
    HitCount = hit_q;
    MissCount = mcnt_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      miss_q <= '0;
      hit_q <= '0;
      mcnt_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      hit_q <= hit_d;
      mcnt_q <= mcnt_d;
      if (done) valid_q[midx] <= 1'b1;
    end
  end
  // Refill cycle r captures the word addressed in cycle r-1 (memory read latency of one).
  always_ff @(posedge CLK) begin
    if (done) tag_q[midx] <= miss_q[27:IW];
    if (refill && cnt_q != 3'd0) data_q[midx][wr_off] <= MemReadData;
    if (st && hit) data_q[idx][off] <= WriteData;
  end
endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: directed plus randomized loads/stores checked against a transaction-level cache model.
module tb_dcache_direct;
  localparam int CW = 4;
  logic CLK = 0, RST = 1, MemRead = 0, MemWrite = 0, MemWE, Stall;
  logic [31:0] Address = 0, WriteData = 0, ReadData, MemAddress, MemWriteData, MemReadData;
  logic [CW-1:0] HitCount, MissCount;
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  bit mv [8];
  int mt [8];
  int exp_hit = 0, exp_miss = 0, tests = 0, fails = 0;

  dcache_direct #(.SETS(8), .LINE_WORDS(4), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .MemWE(MemWE),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemReadData(MemReadData),
    .HitCount(HitCount), .MissCount(MissCount));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MemWE) dmem[MemAddress[9:2]] = MemWriteData;
    MemReadData <= dmem[MemAddress[9:2]];
  end

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("hit_count", 32'(HitCount), 32'(exp_hit % (1 << CW)));
    chk("miss_count", 32'(MissCount), 32'(exp_miss % (1 << CW)));
  endtask

  task automatic do_load(input logic [31:0] a);
    int n, i;
    bit miss;
    logic [31:0] base;
    i = int'((a >> 4) & 7);
    miss = !(mv[i] && mt[i] == int'(a >> 7));
    base = a & ~32'hF;
    @(negedge CLK);
    MemRead = 1;
    Address = a;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 20) begin
      chk("rdata_stall", ReadData, 0);
      if (n >= 1 && n <= 4) chk("refill_addr", MemAddress, base + 32'(4 * (n - 1)));
      @(negedge CLK);
      #1;
      n++;
    end
    chk("stall_cycles", 32'(n), miss ? 6 : 0);
    chk("rdata", ReadData, ref_mem[a[9:2]]);
    if (miss) begin
      exp_miss++;
      mv[i] = 1;
      mt[i] = int'(a >> 7);
    end
    exp_hit++;
    @(negedge CLK);
    MemRead = 0;
    #1;
    chk_cnt();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit rd);
    @(negedge CLK);
    MemWrite = 1;
    MemRead = rd;
    Address = a;
    WriteData = d;
    #1;
    chk("st_we", 32'(MemWE), 1);
    chk("st_addr", MemAddress, a);
    chk("st_wdata", MemWriteData, d);
    chk("st_stall", 32'(Stall), 0);
    ref_mem[a[9:2]] = d;
    @(negedge CLK);
    MemWrite = 0;
    MemRead = 0;
    #1;
    chk("st_we_drop", 32'(MemWE), 0);
    chk_cnt();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ref_mem[k] = $urandom;
      dmem[k] = ref_mem[k];
    end
    for (int k = 0; k < 4; k++) begin
      ref_mem[16 + k] = 32'hA0 + 32'(k);
      dmem[16 + k] = 32'hA0 + 32'(k);
    end
    MemRead = 1;
    Address = 32'h44;
    #1;
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_we", 32'(MemWE), 0);
    chk("rst_rdata", ReadData, 0);
    chk_cnt();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    MemRead = 0;
    do_load(32'h44);
    do_load(32'h40);
    do_load(32'h4C);
    do_store(32'h48, 32'h55, 0);
    do_load(32'h48);
    do_store(32'h100, 32'h77, 1);
    do_load(32'h100);
    do_load(32'hC0);
    do_load(32'h40);
    // Reset in REFILL cycle r=2 with the load still requested.
    @(negedge CLK);
    MemRead = 1;
    Address = 32'h280;
    #1;
    chk("rr_stall_start", 32'(Stall), 1);
    repeat (3) @(negedge CLK);
    chk("rr_addr_r2", MemAddress, 32'h288);
    RST = 1;
    #1;
    chk("rr_stall", 32'(Stall), 0);
    chk("rr_we", 32'(MemWE), 0);
    chk("rr_rdata", ReadData, 0);
    exp_hit = 0;
    exp_miss = 0;
    for (int k = 0; k < 8; k++) mv[k] = 0;
    chk_cnt();
    @(negedge CLK);
    RST = 0;
    MemRead = 0;
    do_load(32'h280);
    do_load(32'h44);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 9) < 3) do_store(a, $urandom, bit'($urandom_range(0, 1)));
      else do_load(a);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage and the data memory, directly upstream of the data memory.
- Serves read hits combinationally in the same cycle.
- Refills a 4-word line on a read miss and stalls the pipeline until the refill completes.
- Forwards every store straight to memory in a single cycle.

Parameters:
- SETS, 8, number of lines; power of two; index = Address[4+log2(SETS)-1:4].
- LINE_WORDS, 4, words per line; fixed at 4; word offset = Address[3:2].
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- MemRead  in  1  pipeline load request.
- MemWrite  in  1  pipeline store request.
- Address  in  32  pipeline byte address; word aligned; bits [1:0] ignored.
- WriteData  in  32  pipeline store data.
- ReadData  out  32  load data to the pipeline.
- Stall  out  1  freezes the pipeline while high.
- MemWE  out  1  data-memory write enable.
- MemAddress  out  32  data-memory byte address.
- MemWriteData  out  32  data-memory write data.
- MemReadData  in  32  data-memory read data, registered; valid one cycle after its address is presented with MemWE=0.
- HitCount  out  CNT_W  load hits since reset; wraps.
- MissCount  out  CNT_W  load misses since reset; wraps.

Behaviour:
- Storage: per line, one valid bit, one tag (Address[31:4+log2(SETS)]) and LINE_WORDS x 32 data words. Data and tags are not reset.
- Reset (RST=1, takes effect immediately):
  - all valid bits cleared;
  - state = IDLE;
  - issue counter and capture counter = 0;
  - HitCount = MissCount = 0;
  - Stall = 0, MemWE = 0, ReadData = 0.
- States: IDLE, REFILL.
- IDLE, MemWrite=1 (takes priority over MemRead if both are high):
  - MemWE=1, MemAddress=Address, MemWriteData=WriteData, Stall=0.
  - If hit, the cached word is updated at the same edge.
  - If miss, no allocation occurs.
- IDLE, MemRead=1, hit (valid and tag match):
  - ReadData = cached word, combinationally; Stall=0.
  - HitCount increments at the edge.
- IDLE, MemRead=1, miss:
  - Stall=1, ReadData=0.
  - At the edge: latch the line base {tag,index,4'b0} into the miss register, MissCount increments, next state REFILL.
- IDLE, no request: Stall=0, MemWE=0, MemAddress=Address, no state change.
- REFILL:
  - Stall=1, MemWE=0, ReadData=0.
  - Cycles r=0..4 of REFILL:
    - for r<=3, MemAddress = missbase + 4*r;
    - for r>=1, MemReadData is written into word r-1 of the line.
  - At the end of r=4: valid set, tag written, next state IDLE.
- Miss timing:
  - A read miss holds Stall high for exactly 6 cycles (1 IDLE plus 5 REFILL).
  - The 7th cycle re-evaluates in IDLE, hits, and returns data with Stall=0.
  - That re-access counts as a hit, so one missed load increments both MissCount and HitCount.
- Pipeline inputs during Stall are ignored; refill uses only the miss register. The pipeline holds its request, which is re-serviced after refill.
- Evicting a valid line (conflict miss) overwrites it without a write-back; write-through guarantees memory is current.
- Reset asserted mid-refill: abort immediately. The partially written line stays invalid and Stall drops in the same cycle.
- Counters wrap from 2^CNT_W-1 to 0.

Test Plan:
1. Preload dmem words 0x40..0x4C = 0xA0..0xA3, reset, load 0x44 -> Stall high 6 cycles; MemAddress 0x40,0x44,0x48,0x4C on REFILL cycles 0..3; 7th cycle ReadData=0xA1, Stall=0; MissCount=1, HitCount=1.
2. Follow-up loads 0x40, 0x4C -> zero stall; ReadData 0xA0, 0xA3; HitCount=3.
3. Store 0x48 <- 0x55 (hit) -> MemWE=1 for one cycle with MemAddress=0x48; next load 0x48 returns 0x55 with no stall.
4. Store 0x100 <- 0x77 (miss) -> MemWE pulse, no stall; following load 0x100 misses (6-cycle stall) and returns 0x77.
5. Load 0xC0 (same index as 0x40, different tag) -> conflict refill; later load 0x40 misses again; MissCount increments each time.
6. Assert RST during REFILL cycle 2 -> Stall=0 and MemWE=0 immediately; after release, load of that same address misses and refills fully.
